skinny_dom_sequencer: RTL and testbench
=======================================

// Module: skinny_dom_sequencer
// PURPOSE
//  Request-level controller for the 2-share DOM SKINNY-128-384+ core. Accepts plaintext/key/tweaks,
//  collects fresh randomness from a word stream, splits state and key into Boolean shares,
//  pulses the core start, supervises completion with a timeout, and recombines shares into ciphertext.
//  Sits between the UART/host front end and the masked core.
// PARAMETERS
//  RW        32   random word width; must divide RND_BITS (1472)
//  TIMEOUT   256  max RUN cycles awaiting core done before abort (core nominal 200)
//  CRST_CYC  2    cycles core_rst_n_o held low after reset/abort
// PORTS
//  clk_i          in   1     clock
//  rst_i          in   1     synchronous active-high reset
//  in_valid_i     in   1     request valid
//  in_ready_o     out  1     request ready (IDLE only)
//  pt_i           in   128   plaintext
//  key_i          in   128   key (TK3)
//  tweak1_i       in   128   TK1
//  tweak2_i       in   128   TK2
//  rnd_valid_i    in   1     random word valid
//  rnd_ready_o    out  1     random word ready
//  rnd_i          in   RW    random word
//  core_rst_n_o   out  1     core reset, active-low
//  core_start_o   out  1     one-cycle start pulse
//  core_input_o   out  256  state shares {sh1,sh0}
//  core_key_o     out  256  key shares {sh1,sh0}
//  core_tweak1_o  out  128   TK1 (unmasked)
//  core_tweak2_o  out  128   TK2 (unmasked)
//  core_random_o  out  1216  DOM randomness
//  core_cipher_i  in   256   core result shares {sh1,sh0}
//  core_done_i    in   1     core done level
//  out_valid_o    out  1     ciphertext valid
//  out_ready_i    in   1     ciphertext accepted
//  ct_o           out  128   ciphertext
//  busy_o         out  1     state != IDLE
//  err_o          out  1     sticky timeout flag
// BEHAVIOUR
//  RND_BITS=1216+256; RND_WORDS=RND_BITS/RW. Buffer buf shifts MSB-first: buf<={buf[RND_BITS-RW-1:0],rnd_i}
//   on rnd_valid_i&rnd_ready_o; cnt++. Fields: buf[1471:256]->core_random_o, buf[255:128]=m, buf[127:0]=k.
//  rnd_ready_o = (cnt<RND_WORDS) in every state except CRST and PREP; refill overlaps RUN/UNMASK/OUT.
//  FSM: CRST -> IDLE -> WAITR -> PREP -> START -> RUN -> UNMASK -> OUT -> IDLE.
//   CRST: core_rst_n_o=0 for CRST_CYC cycles, then IDLE.
//   IDLE: in_ready_o=1; on in_valid_i register pt/key/tweaks, clear err_o; go PREP if cnt==RND_WORDS else WAITR.
//   WAITR: stay until cnt==RND_WORDS.
//   PREP: register core_input_o<={m,pt^m}, core_key_o<={k,key^k}, core_random_o<=buf field; zero pt/key regs;
//         cnt<=0; buf<=0.
//   START: core_start_o=1 for exactly this cycle; shares/random/tweaks stable from PREP until OUT exit.
//   RUN: cycle counter from 0; core_done_i ignored in first RUN cycle; done_i=1 -> UNMASK.
//        counter==TIMEOUT-1 without done -> err_o<=1, CRST (no output).
//   UNMASK: ct_o<=core_cipher_i[255:128]^core_cipher_i[127:0].
//   OUT: out_valid_o=1 held, ct_o stable until out_ready_i; then IDLE with out_valid_o=0 next cycle.
//  Latency: out_valid_o rises 2 cycles after first accepted core_done_i=1.
//  Reset (any time, incl. mid-RUN): state CRST, cnt=0, buf=0, all core_* data regs 0, core_start_o=0,
//   core_rst_n_o=0, in_ready_o=0, rnd_ready_o=0, out_valid_o=0, ct_o=0, err_o=0, busy_o=1.
//  Simultaneous in_valid_i and rnd word in IDLE: both accepted same cycle; count includes that word.
//  rnd_valid_i while cnt==RND_WORDS: not accepted (ready low), buffer unchanged.
//  Shares never recombined except in UNMASK; unmasked pt/key not held past PREP.
// TESTING
//  Zero vector, all-zero random vs random-filled buffer -> identical ct_o; matches C reference ct.
//  Random words pre-filled (46 x 32b) before request -> PREP directly after IDLE; one start pulse; out 2 cyc after done.
//  Request with empty buffer, 1 word per 3 cycles -> WAITR 138 cycles, then correct ct_o.
//  Core model never asserts done -> err_o=1 after 256 RUN cycles, core_rst_n_o low 2 cycles, no out_valid_o.
//  out_ready_i low 10 cycles -> out_valid_o/ct_o held constant; in_ready_o stays 0 until after accept.
//  rst_i pulse mid-RUN -> all outputs at reset values next cycle, core_rst_n_o low, subsequent request correct.

Source files
------------

// File: rtl/skinny_dom_sequencer.sv
// Request sequencer for the 2-share DOM SKINNY-128-384+ core: gathers fresh randomness,
// masks plaintext/key into Boolean shares, supervises the core run and unmasks the ciphertext.
module skinny_dom_sequencer #(
  parameter int RW       = 32,
  parameter int TIMEOUT  = 256,
  parameter int CRST_CYC = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [127:0]   pt_i,
  input  logic [127:0]   key_i,
  input  logic [127:0]   tweak1_i,
  input  logic [127:0]   tweak2_i,
  input  logic           rnd_valid_i,
  output logic           rnd_ready_o,
  input  logic [RW-1:0]  rnd_i,
  output logic           core_rst_n_o,
  output logic           core_start_o,
  output logic [255:0]   core_input_o,
  output logic [255:0]   core_key_o,
  output logic [127:0]   core_tweak1_o,
  output logic [127:0]   core_tweak2_o,
  output logic [1215:0]  core_random_o,
  input  logic [255:0]   core_cipher_i,
  input  logic           core_done_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [127:0]   ct_o,
  output logic           busy_o,
  output logic           err_o
);

  localparam int RND_BITS  = 1216 + 256;
  localparam int RND_WORDS = RND_BITS / RW;
  localparam int CNT_W     = $clog2(RND_WORDS + 1);
  localparam int RUN_W     = $clog2(TIMEOUT);
  localparam int CRST_W    = $clog2(CRST_CYC + 1);
  localparam logic [CNT_W-1:0]  RND_WORDS_C = CNT_W'(RND_WORDS);
  localparam logic [RUN_W-1:0]  RUN_LAST    = RUN_W'(TIMEOUT - 1);
  localparam logic [CRST_W-1:0] CRST_LAST   = CRST_W'(CRST_CYC - 1);

  typedef enum logic [2:0] {
    S_CRST, S_IDLE, S_WAITR, S_PREP, S_START, S_RUN, S_UNMASK, S_OUT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RND_BITS-1:0]  buf_q, buf_d;
  logic [CRST_W-1:0]    crst_q, crst_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [127:0]         pt_q, pt_d, tk3_q, tk3_d, tw1_q, tw1_d, tw2_q, tw2_d;
  logic [255:0]         state_sh_q, state_sh_d, key_sh_q, key_sh_d;
  logic [1215:0]        rand_q, rand_d;
  logic [127:0]         ct_q, ct_d;
  logic                 err_q, err_d;
  logic                 rnd_fire;

  assign in_ready_o    = (state_q == S_IDLE);
  assign rnd_ready_o   = (cnt_q < RND_WORDS_C) && (state_q != S_CRST) && (state_q != S_PREP);
  assign core_rst_n_o  = (state_q != S_CRST);
  assign core_start_o  = (state_q == S_START);
  assign out_valid_o   = (state_q == S_OUT);
  assign busy_o        = (state_q != S_IDLE);
  assign err_o         = err_q;
  assign ct_o          = ct_q;
  assign core_input_o  = state_sh_q;
  assign core_key_o    = key_sh_q;
  assign core_random_o = rand_q;
  assign core_tweak1_o = tw1_q;
  assign core_tweak2_o = tw2_q;
  assign rnd_fire      = rnd_valid_i && rnd_ready_o;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    crst_d     = crst_q;
    run_d      = run_q;
    pt_d       = pt_q;
    tk3_d      = tk3_q;
    tw1_d      = tw1_q;
    tw2_d      = tw2_q;
    state_sh_d = state_sh_q;
    key_sh_d   = key_sh_q;
    rand_d     = rand_q;
    ct_d       = ct_q;
    err_d      = err_q;

    // The randomness refill runs in parallel with the request FSM.
    if (rnd_fire) begin
      buf_d = {buf_q[RND_BITS-RW-1:0], rnd_i};
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_CRST: begin
        if (crst_q == CRST_LAST) state_d = S_IDLE;
        else                     crst_d  = crst_q + CRST_W'(1);
      end
      S_IDLE: begin
        if (in_valid_i) begin
          pt_d    = pt_i;
          tk3_d   = key_i;
          tw1_d   = tweak1_i;
          tw2_d   = tweak2_i;
          err_d   = 1'b0;
          state_d = (cnt_d == RND_WORDS_C) ? S_PREP : S_WAITR;
        end
      end
      S_WAITR: begin
        if (cnt_q == RND_WORDS_C) state_d = S_PREP;
      end
      S_PREP: begin
        // Masks are consumed here and the plain values dropped in the same cycle.
        state_sh_d = {buf_q[255:128], pt_q ^ buf_q[255:128]};
        key_sh_d   = {buf_q[127:0], tk3_q ^ buf_q[127:0]};
        rand_d     = buf_q[RND_BITS-1:256];
        pt_d       = '0;
        tk3_d      = '0;
        cnt_d      = '0;
        buf_d      = '0;
        state_d    = S_START;
      end
      S_START: begin
        run_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if ((run_q != '0) && core_done_i) begin
          state_d = S_UNMASK;
        end else if (run_q == RUN_LAST) begin
          err_d   = 1'b1;
          crst_d  = '0;
          state_d = S_CRST;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
      S_UNMASK: begin
        ct_d    = core_cipher_i[255:128] ^ core_cipher_i[127:0];
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_CRST;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_CRST;
      cnt_q      <= '0;
      buf_q      <= '0;
      crst_q     <= '0;
      run_q      <= '0;
      pt_q       <= '0;
      tk3_q      <= '0;
      tw1_q      <= '0;
      tw2_q      <= '0;
      state_sh_q <= '0;
      key_sh_q   <= '0;
      rand_q     <= '0;
      ct_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      crst_q     <= crst_d;
      run_q      <= run_d;
      pt_q       <= pt_d;
      tk3_q      <= tk3_d;
      tw1_q      <= tw1_d;
      tw2_q      <= tw2_d;
      state_sh_q <= state_sh_d;
      key_sh_q   <= key_sh_d;
      rand_q     <= rand_d;
      ct_q       <= ct_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_skinny_dom_sequencer.sv
// Directed bench for skinny_dom_sequencer with a behavioural masked-core stand-in and
// scoreboards for ciphertexts and randomness batches.
module tb_skinny_dom_sequencer;
  localparam int RW = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0, in_ready;
  logic [127:0]   pt = '0, key = '0, tw1 = '0, tw2 = '0;
  logic           rnd_valid = 1'b0, rnd_ready;
  logic [RW-1:0]  rnd = '0;
  logic           core_rst_n, core_start;
  logic [255:0]   core_input, core_key;
  logic [127:0]   core_tweak1, core_tweak2;
  logic [1215:0]  core_random;
  logic [255:0]   core_cipher = '0;
  logic           core_done = 1'b0;
  logic           out_valid, out_ready = 1'b1;
  logic [127:0]   ct;
  logic           busy, err;

  always #5 clk = ~clk;

  skinny_dom_sequencer #(.RW(RW), .TIMEOUT(256), .CRST_CYC(2)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pt_i(pt), .key_i(key), .tweak1_i(tw1), .tweak2_i(tw2),
    .rnd_valid_i(rnd_valid), .rnd_ready_o(rnd_ready), .rnd_i(rnd),
    .core_rst_n_o(core_rst_n), .core_start_o(core_start),
    .core_input_o(core_input), .core_key_o(core_key),
    .core_tweak1_o(core_tweak1), .core_tweak2_o(core_tweak2),
    .core_random_o(core_random), .core_cipher_i(core_cipher), .core_done_i(core_done),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .ct_o(ct),
    .busy_o(busy), .err_o(err)
  );

  int n_checks = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in cipher: any fixed mixing of the unmasked inputs serves to prove the shares were right.
  function automatic logic [127:0] fref(input logic [127:0] p, k, a, b);
    return {p[63:0], p[127:64]} ^ k ^ {a[126:0], a[127]} ^ {b[2:0], b[127:3]}
           ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  // Behavioural core: recombines its shares, answers with freshly re-masked result shares.
  int           lat = 10;
  bit           never_done = 1'b0;
  logic         cm_busy = 1'b0;
  int           cm_cnt = 0;
  logic [127:0] cm_ct = '0, rmask = '0;
  always @(posedge clk) begin
    rmask <= {$urandom(), $urandom(), $urandom(), $urandom()};
    if (!core_rst_n) begin
      cm_busy     <= 1'b0;
      core_done   <= 1'b0;
      core_cipher <= '0;
    end else if (core_start) begin
      cm_busy   <= 1'b1;
      cm_cnt    <= lat;
      core_done <= 1'b0;
      cm_ct     <= fref(core_input[255:128] ^ core_input[127:0],
                        core_key[255:128] ^ core_key[127:0], core_tweak1, core_tweak2);
    end else if (cm_busy && !never_done) begin
      if (cm_cnt == 0) begin
        core_done   <= 1'b1;
        cm_busy     <= 1'b0;
        core_cipher <= {rmask, cm_ct ^ rmask};
      end else begin
        cm_cnt <= cm_cnt - 1;
      end
    end
  end

  logic [127:0]  sb_q[$];
  logic [1471:0] rnd_q[$];
  logic [1471:0] mbuf = '0;
  int            mcnt = 0;
  logic [127:0]  cur_t1 = '0, cur_t2 = '0;
  int            req_cyc = 0, start_cyc = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic feed(input int n, input int gap, input bit zero, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rnd_valid = 1'b1;
      rnd = zero ? '0 : RW'($urandom());
      if (rnd_ready) begin
        acc++;
        mbuf = {mbuf[1471-RW:0], rnd};
        mcnt++;
        if (mcnt == 46) begin
          rnd_q.push_back(mbuf);
          mbuf = '0;
          mcnt = 0;
        end
      end
      repeat (gap) begin
        @(negedge clk);
        rnd_valid = 1'b0;
      end
    end
    @(negedge clk);
    rnd_valid = 1'b0;
  endtask

  task automatic drive_req(input logic [127:0] p, k, a, b, input bit push);
    @(negedge clk);
    chk("in_ready_before_req", {127'b0, in_ready}, 128'd1);
    in_valid = 1'b1;
    pt = p; key = k; tw1 = a; tw2 = b;
    if (push) sb_q.push_back(fref(p, k, a, b));
    cur_t1 = a; cur_t2 = b;
    req_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    pt = '0; key = '0; tw1 = '0; tw2 = '0;
  endtask

  task automatic wait_start();
    logic [1471:0] b;
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (core_start) seen = 1'b1;
    end
    chk("start_seen", {127'b0, seen}, 128'd1);
    start_cyc = cyc;
    if (rnd_q.size() == 0) begin
      chk("rnd_batch_available", 128'd0, 128'd1);
    end else begin
      b = rnd_q.pop_front();
      chk("core_random_field", {127'b0, core_random === b[1471:256]}, 128'd1);
      chk("state_share1", core_input[255:128], b[255:128]);
      chk("key_share1", core_key[255:128], b[127:0]);
      chk("tweak1", core_tweak1, cur_t1);
      chk("tweak2", core_tweak2, cur_t2);
    end
  endtask

  task automatic wait_out(output logic [127:0] got);
    int done_cyc = -100, extra_starts = 0;
    bit seen = 1'b0;
    logic [127:0] exp;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (core_start) extra_starts++;
      if (core_done && done_cyc < 0) done_cyc = cyc;
      if (out_valid) seen = 1'b1;
    end
    chk("out_valid_seen", {127'b0, seen}, 128'd1);
    chk("single_start_pulse", 128'(extra_starts), 128'd0);
    chk("done_to_out_latency", 128'(cyc - done_cyc), 128'd2);
    got = ct;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 128'hx;
    chk("ct", ct, exp);
  endtask

  initial begin
    int acc;
    logic [127:0] ct_a, ct_b, ct_hold;
    int err_cyc;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_core_rst_n", {127'b0, core_rst_n}, 128'd0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
    chk("rst_rnd_ready", {127'b0, rnd_ready}, 128'd0);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_busy", {127'b0, busy}, 128'd1);
    chk("rst_err", {127'b0, err}, 128'd0);
    chk("rst_ct", ct, 128'd0);
    chk("rst_start", {127'b0, core_start}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("crst_hold", {127'b0, core_rst_n}, 128'd0);
    @(negedge clk);
    chk("crst_release", {127'b0, core_rst_n}, 128'd1);
    chk("idle_in_ready", {127'b0, in_ready}, 128'd1);
    chk("idle_busy", {127'b0, busy}, 128'd0);

    // Zero vector with all-zero randomness, buffer pre-filled
    feed(46, 0, 1'b1, acc);
    chk("prefill_accepted", 128'(acc), 128'd46);
    chk("full_rnd_ready", {127'b0, rnd_ready}, 128'd0);
    feed(1, 0, 1'b0, acc);
    chk("full_word_rejected", 128'(acc), 128'd0);
    drive_req('0, '0, '0, '0, 1'b1);
    wait_start();
    chk("prefilled_req_to_start", 128'(start_cyc - req_cyc), 128'd2);
    wait_out(ct_a);

    // Same vector with random masks must unmask to the same ciphertext
    feed(46, 0, 1'b0, acc);
    drive_req('0, '0, '0, '0, 1'b1);
    wait_start();
    wait_out(ct_b);
    chk("ct_mask_independent", ct_b, ct_a);

    // Empty buffer, one word every third cycle, overlapping the request
    fork
      feed(46, 2, 1'b0, acc);
      begin
        drive_req(128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 128'hdead_beef_0bad_f00d_1234_5678_9abc_def0,
                  128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b1);
        wait_start();
        chk("waitr_req_to_start", 128'(start_cyc - req_cyc), 128'd138);
      end
    join
    wait_out(ct_b);

    // Output back-pressure
    feed(46, 0, 1'b0, acc);
    out_ready = 1'b0;
    drive_req(128'hffff_0000_ffff_0000_1111_2222_3333_4444, 128'h5555_aaaa_5555_aaaa_0000_ffff_0000_ffff,
              128'h1, 128'h2, 1'b1);
    wait_start();
    wait_out(ct_hold);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {127'b0, out_valid}, 128'd1);
      chk("hold_ct", ct, ct_hold);
      chk("hold_in_ready", {127'b0, in_ready}, 128'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("accept_out_valid_low", {127'b0, out_valid}, 128'd0);
    chk("accept_in_ready", {127'b0, in_ready}, 128'd1);

    // Core never finishes: timeout abort
    feed(46, 0, 1'b0, acc);
    never_done = 1'b1;
    drive_req(128'h42, 128'h43, 128'h44, 128'h45, 1'b0);
    wait_start();
    seen = 1'b0;
    err_cyc = -1;
    for (int i = 0; i < 400 && err_cyc < 0; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      if (err) err_cyc = cyc;
    end
    chk("timeout_cycles", 128'(err_cyc - start_cyc), 128'd257);
    chk("timeout_no_out", {127'b0, seen}, 128'd0);
    chk("abort_core_rst_n_0", {127'b0, core_rst_n}, 128'd0);
    @(negedge clk);
    chk("abort_core_rst_n_1", {127'b0, core_rst_n}, 128'd0);
    @(negedge clk);
    chk("abort_core_rst_released", {127'b0, core_rst_n}, 128'd1);
    chk("err_sticky", {127'b0, err}, 128'd1);
    chk("abort_no_out", {127'b0, out_valid}, 128'd0);
    never_done = 1'b0;

    // Reset pulse mid-RUN, then a normal request
    feed(46, 0, 1'b0, acc);
    lat = 50;
    drive_req(128'h77, 128'h88, 128'h99, 128'haa, 1'b0);
    chk("new_req_clears_err", {127'b0, err}, 128'd0);
    wait_start();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_core_rst_n", {127'b0, core_rst_n}, 128'd0);
    chk("midrun_start", {127'b0, core_start}, 128'd0);
    chk("midrun_in_ready", {127'b0, in_ready}, 128'd0);
    chk("midrun_rnd_ready", {127'b0, rnd_ready}, 128'd0);
    chk("midrun_out_valid", {127'b0, out_valid}, 128'd0);
    chk("midrun_busy", {127'b0, busy}, 128'd1);
    chk("midrun_ct", ct, 128'd0);
    chk("midrun_core_input", core_input[127:0] | core_input[255:128], 128'd0);
    chk("midrun_core_random", {127'b0, core_random === '0}, 128'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    lat = 10;
    feed(46, 0, 1'b0, acc);
    drive_req(128'hcafe_babe_0000_1111_2222_3333_4444_5555, 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10,
              128'h3, 128'h4, 1'b1);
    wait_start();
    wait_out(ct_b);
    @(negedge clk);
    chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
